// File: rtl/twiddle_cmult.sv
// Complex sample x twiddle multiplier: three-stage pipeline (register, multiply, add/sub)
// with frame-index tagging for the downstream saturation stage. Full precision, no rounding.
module twiddle_cmult #(
   parameter  int NBITS_IN  = 8,
   parameter  int NBF_IN    = 7,
   parameter  int NBITS_TW  = 8,
   parameter  int NBF_TW    = 7,
   parameter  int NPOINT    = 128,
   localparam int NBITS_OUT = NBITS_IN + NBITS_TW + 1,
   localparam int NBF_OUT   = NBF_IN + NBF_TW,
   localparam int NIDX      = $clog2(NPOINT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_en,
   input  logic                        i_valid,
   input  logic                        i_sync,
   input  logic signed [NBITS_IN-1:0]  i_re,
   input  logic signed [NBITS_IN-1:0]  i_im,
   input  logic signed [NBITS_TW-1:0]  i_tw_re,
   input  logic signed [NBITS_TW-1:0]  i_tw_im,
   output logic signed [NBITS_OUT-1:0] o_re,
   output logic signed [NBITS_OUT-1:0] o_im,
   output logic                        o_valid,
   output logic [NIDX-1:0]             o_idx,
   output logic                        o_last
);

   localparam int              NPROD    = NBITS_IN + NBITS_TW;
   localparam logic [NIDX-1:0] LAST_IDX = NIDX'(NPOINT - 1);

   // Reject frame lengths and fixed-point formats the index counter and product width cannot represent.
   if (NPOINT < 4 || (NPOINT & (NPOINT - 1)) != 0 || NBF_IN >= NBITS_IN || NBF_TW >= NBITS_TW
       || NBF_OUT >= NBITS_OUT) begin : g_bad_cfg
      $error("twiddle_cmult: unsupported parameter set");
   end

   logic [NIDX-1:0]             cnt_q, cnt_d, tag_d;
   logic                        vld_q1, vld_q2, vld_q3;
   logic [NIDX-1:0]             idx_q1, idx_q2, idx_q3;
   logic signed [NBITS_IN-1:0]  re_q1, im_q1;
   logic signed [NBITS_TW-1:0]  tw_re_q1, tw_im_q1;
   logic signed [NPROD-1:0]     p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   logic signed [NPROD-1:0]     p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [NBITS_OUT-1:0] sum_re_d, sum_im_d, sum_re_q, sum_im_q;

   // Sync restarts the frame: this sample is index 0, so the next one is index 1.
   always_comb begin
      tag_d = i_sync ? '0 : cnt_q;
      cnt_d = cnt_q;
      if (i_valid) begin
         cnt_d = i_sync ? NIDX'(1) : cnt_q + NIDX'(1);
      end
   end

   always_comb begin
      p_rr_d   = NPROD'(re_q1) * NPROD'(tw_re_q1);
      p_ii_d   = NPROD'(im_q1) * NPROD'(tw_im_q1);
      p_ri_d   = NPROD'(re_q1) * NPROD'(tw_im_q1);
      p_ir_d   = NPROD'(im_q1) * NPROD'(tw_re_q1);
      sum_re_d = NBITS_OUT'(p_rr_q) - NBITS_OUT'(p_ii_q);
      sum_im_d = NBITS_OUT'(p_ri_q) + NBITS_OUT'(p_ir_q);
   end

   // Valid bits advance on every enabled cycle; data/index only load behind a valid, so bubbles hold the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         vld_q1   <= 1'b0;
         vld_q2   <= 1'b0;
         vld_q3   <= 1'b0;
         idx_q1   <= '0;
         idx_q2   <= '0;
         idx_q3   <= '0;
         re_q1    <= '0;
         im_q1    <= '0;
         tw_re_q1 <= '0;
         tw_im_q1 <= '0;
         p_rr_q   <= '0;
         p_ii_q   <= '0;
         p_ri_q   <= '0;
         p_ir_q   <= '0;
         sum_re_q <= '0;
         sum_im_q <= '0;
      end else if (i_en) begin
         cnt_q  <= cnt_d;
         vld_q1 <= i_valid;
         vld_q2 <= vld_q1;
         vld_q3 <= vld_q2;
         if (i_valid) begin
            idx_q1   <= tag_d;
            re_q1    <= i_re;
            im_q1    <= i_im;
            tw_re_q1 <= i_tw_re;
            tw_im_q1 <= i_tw_im;
         end
         if (vld_q1) begin
            idx_q2 <= idx_q1;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
         end
         if (vld_q2) begin
            idx_q3   <= idx_q2;
            sum_re_q <= sum_re_d;
            sum_im_q <= sum_im_d;
         end
      end
   end

   assign o_re    = sum_re_q;
   assign o_im    = sum_im_q;
   assign o_valid = vld_q3;
   assign o_idx   = idx_q3;
   assign o_last  = vld_q3 && (idx_q3 == LAST_IDX);

endmodule

// File: tb/tb_twiddle_cmult.sv
// Directed and random checks of twiddle_cmult at default parameters (8x8 -> 17-bit, 128-point frames).
module tb_twiddle_cmult;

   logic               clk = 1'b0;
   logic               rst, en, valid, sync;
   logic signed [7:0]  re, im, twr, twi;
   logic signed [16:0] o_re, o_im;
   logic               o_valid, o_last;
   logic [6:0]         o_idx;
   int                 n_cmp = 0;
   int                 n_err = 0;

   typedef struct {
      logic signed [16:0] re;
      logic signed [16:0] im;
      logic [6:0]         idx;
      int                 en_n;
   } exp_t;

   twiddle_cmult dut (
      .clk     (clk),
      .rst     (rst),
      .i_en    (en),
      .i_valid (valid),
      .i_sync  (sync),
      .i_re    (re),
      .i_im    (im),
      .i_tw_re (twr),
      .i_tw_im (twi),
      .o_re    (o_re),
      .o_im    (o_im),
      .o_valid (o_valid),
      .o_idx   (o_idx),
      .o_last  (o_last)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input int a, input int b, input int c, input int d);
      valid = v;
      sync  = s;
      re    = 8'(a);
      im    = 8'(b);
      twr   = 8'(c);
      twi   = 8'(d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      drive(1'b1, 1'b1, 11, 22, 33, 44);
      step();
      step();
      n_cmp++;
      if ({o_valid, o_last} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_flags: got valid=%0b last=%0b want 0 0", o_valid, o_last);
      end
      n_cmp++;
      if ({o_idx, o_re, o_im} !== 41'd0) begin
         n_err++;
         $display("FAIL reset_data: got idx=%0d re=%0d im=%0d want 0 0 0", o_idx, o_re, o_im);
      end
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      drive(1'b1, 1'b1, 64, 0, 127, 0);
      step();
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      step();
      step();
      n_cmp++;
      if ({o_valid, o_last, o_idx} !== {1'b1, 1'b0, 7'd0}) begin
         n_err++;
         $display("FAIL basic_ctrl: got valid=%0b last=%0b idx=%0d want 1 0 0", o_valid, o_last, o_idx);
      end
      n_cmp++;
      if (o_re !== 17'sd8128) begin
         n_err++;
         $display("FAIL basic_re: got %0d want 8128", o_re);
      end
      n_cmp++;
      if (o_im !== 17'sd0) begin
         n_err++;
         $display("FAIL basic_im: got %0d want 0", o_im);
      end
      step();
      n_cmp++;
      if ({o_valid, o_re} !== {1'b0, 17'sd8128}) begin
         n_err++;
         $display("FAIL basic_hold: got valid=%0b re=%0d want 0 8128", o_valid, o_re);
      end
   endtask

   task automatic test_most_negative();
      drive(1'b1, 1'b0, -128, -128, -128, -128);
      step();
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      step();
      step();
      n_cmp++;
      if ({o_valid, o_idx} !== {1'b1, 7'd1}) begin
         n_err++;
         $display("FAIL mostneg_ctrl: got valid=%0b idx=%0d want 1 1", o_valid, o_idx);
      end
      n_cmp++;
      if ({o_re, o_im} !== {17'h00000, 17'h08000}) begin
         n_err++;
         $display("FAIL mostneg_data: got re=%0h im=%0h want 0 8000", o_re, o_im);
      end
   endtask

   task automatic test_mixed_sign();
      drive(1'b1, 1'b0, 3, -5, 7, 2);
      step();
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      step();
      step();
      n_cmp++;
      if ({o_valid, o_idx, o_re, o_im} !== {1'b1, 7'd2, 17'sd31, -17'sd29}) begin
         n_err++;
         $display("FAIL mixed_sign: got valid=%0b idx=%0d re=%0d im=%0d want 1 2 31 -29",
                  o_valid, o_idx, o_re, o_im);
      end
   endtask

   task automatic test_frame();
      int m, exp_re, exp_im;
      for (int j = 0; j < 132; j++) begin
         if (j < 130) drive(1'b1, j == 0, j - 64, 3, 100, -50);
         else         drive(1'b0, 1'b0, 0, 0, 0, 0);
         step();
         if (j >= 2) begin
            m      = j - 2;
            exp_re = (m - 64) * 100 + 150;
            exp_im = (m - 64) * (-50) + 300;
            n_cmp++;
            if ({o_valid, o_idx, o_last} !== {1'b1, 7'(m % 128), m == 127}) begin
               n_err++;
               $display("FAIL frame_ctrl[%0d]: got valid=%0b idx=%0d last=%0b want 1 %0d %0b",
                        m, o_valid, o_idx, o_last, m % 128, m == 127);
            end
            n_cmp++;
            if ({o_re, o_im} !== {17'(exp_re), 17'(exp_im)}) begin
               n_err++;
               $display("FAIL frame_data[%0d]: got re=%0d im=%0d want %0d %0d", m, o_re, o_im, exp_re, exp_im);
            end
         end
      end
   endtask

   task automatic test_enable_freeze();
      int          k = 0;
      int          e = 0;
      int          m, exp_re, exp_im;
      logic [42:0] snap = '0;
      for (int c = 0; c < 20; c++) begin
         en = !(c >= 5 && c < 10);
         if (!en)        drive(1'b1, 1'b1, 99, 99, 99, 99);
         else if (k < 8) begin
            drive(1'b1, k == 0, 10 * (k + 1), -k, 64, -64);
            k++;
         end else        drive(1'b0, 1'b0, 0, 0, 0, 0);
         step();
         if (en) begin
            e++;
            if (e >= 3 && e - 3 < 8) begin
               m      = e - 3;
               exp_re = 64 * (10 * (m + 1)) - 64 * m;
               exp_im = -64 * (10 * (m + 1)) - 64 * m;
               n_cmp++;
               if ({o_valid, o_idx, o_re, o_im} !== {1'b1, 7'(m), 17'(exp_re), 17'(exp_im)}) begin
                  n_err++;
                  $display("FAIL freeze_seq[%0d]: got valid=%0b idx=%0d re=%0d im=%0d want 1 %0d %0d %0d",
                           m, o_valid, o_idx, o_re, o_im, m, exp_re, exp_im);
               end
            end else if (e >= 3) begin
               n_cmp++;
               if (o_valid !== 1'b0) begin
                  n_err++;
                  $display("FAIL freeze_dup: got valid=%0b want 0 at enabled edge %0d", o_valid, e);
               end
            end
            snap = {o_valid, o_last, o_idx, o_re, o_im};
         end else begin
            n_cmp++;
            if ({o_valid, o_last, o_idx, o_re, o_im} !== snap) begin
               n_err++;
               $display("FAIL freeze_hold[c=%0d]: got %0h want %0h", c,
                        {o_valid, o_last, o_idx, o_re, o_im}, snap);
            end
         end
      end
      en = 1'b1;
   endtask

   task automatic test_reset_inflight();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, k == 0, 20 + k, 1, 2, 3);
         step();
      end
      n_cmp++;
      if (o_valid !== 1'b1) begin
         n_err++;
         $display("FAIL inflight_pre: got valid=%0b want 1", o_valid);
      end
      drive(1'b1, 1'b0, 50, 50, 50, 50);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({o_valid, o_last, o_idx, o_re, o_im} !== 43'd0) begin
         n_err++;
         $display("FAIL inflight_async: got valid=%0b idx=%0d re=%0d im=%0d want all 0", o_valid, o_idx, o_re, o_im);
      end
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         n_cmp++;
         if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL inflight_ghost[%0d]: got valid=%0b want 0", k, o_valid);
         end
      end
      drive(1'b1, 1'b0, 5, 6, 7, 8);
      step();
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      step();
      step();
      n_cmp++;
      if ({o_valid, o_idx, o_re, o_im} !== {1'b1, 7'd0, -17'sd13, 17'sd82}) begin
         n_err++;
         $display("FAIL inflight_restart: got valid=%0b idx=%0d re=%0d im=%0d want 1 0 -13 82",
                  o_valid, o_idx, o_re, o_im);
      end
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        x;
      int          ecount = 0;
      logic [6:0]  mcnt = '0;
      logic        first = 1'b1;
      logic [31:0] r, d;
      int          a, b, c, dd;
      for (int i = 0; i < 10003; i++) begin
         r = $urandom();
         d = $urandom();
         if (i >= 10000) begin
            en = 1'b1;
            drive(1'b0, 1'b0, 0, 0, 0, 0);
         end else begin
            en = first || (r[3:0] != 4'd0);
            drive(first || (r[5:4] != 2'd0), first || (r[11:6] == 6'd0),
                  int'($signed(d[7:0])), int'($signed(d[15:8])),
                  int'($signed(d[23:16])), int'($signed(d[31:24])));
         end
         if (en && valid) begin
            a      = re;
            b      = im;
            c      = twr;
            dd     = twi;
            x.re   = 17'(a * c - b * dd);
            x.im   = 17'(a * dd + b * c);
            x.idx  = sync ? 7'd0 : mcnt;
            x.en_n = ecount + 1;
            mcnt   = sync ? 7'd1 : mcnt + 7'd1;
            q.push_back(x);
            first  = 1'b0;
         end
         step();
         if (en) begin
            ecount++;
            n_cmp++;
            if (q.size() > 0 && q[0].en_n + 2 == ecount) begin
               x = q.pop_front();
               if ({o_valid, o_idx, o_re, o_im} !== {1'b1, x.idx, x.re, x.im}) begin
                  n_err++;
                  $display("FAIL random[%0d]: got valid=%0b idx=%0d re=%0d im=%0d want 1 %0d %0d %0d",
                           i, o_valid, o_idx, o_re, o_im, x.idx, x.re, x.im);
               end
            end else if (o_valid !== 1'b0) begin
               n_err++;
               $display("FAIL random_bubble[%0d]: got valid=%0b want 0", i, o_valid);
            end
         end
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL random_drain: got %0d samples left want 0", q.size());
      end
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b1;
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      #2;
      test_reset();
      test_basic();
      test_most_negative();
      test_mixed_sign();
      test_frame();
      test_enable_freeze();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/twiddle_cmult.md
TWIDDLE_CMULT -- requirements
Module: twiddle_cmult

Interface
REQ-001 SHALL have parameter NBITS_IN, default 8, signed data width of each input component (re/im).
REQ-002 SHALL have parameter NBF_IN, default 7, fractional bits of input data.
REQ-003 SHALL have parameter NBITS_TW, default 8, signed twiddle width of each component.
REQ-004 SHALL have parameter NBF_TW, default 7, fractional bits of twiddle.
REQ-005 SHALL have parameter NPOINT, default 128, frame length in samples; power of two, >= 4.
REQ-006 SHALL derive localparams NBITS_OUT = NBITS_IN+NBITS_TW+1, NBF_OUT = NBF_IN+NBF_TW, NIDX = log2(NPOINT).
REQ-007 SHALL have port clk  input  1  sole clock; all state rising-edge triggered.
REQ-008 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-009 SHALL have port i_en  input  1  pipeline enable; low freezes all state.
REQ-010 SHALL have port i_valid  input  1  input sample qualifier.
REQ-011 SHALL have port i_sync  input  1  marks current input sample as frame index 0.
REQ-012 SHALL have ports i_re, i_im  input  NBITS_IN each  signed data sample.
REQ-013 SHALL have ports i_tw_re, i_tw_im  input  NBITS_TW each  signed twiddle, aligned with the data sample.
REQ-014 SHALL have ports o_re, o_im  output  NBITS_OUT each  full-precision signed product, format NBF_OUT fractional bits, for the downstream saturation stage.
REQ-015 SHALL have port o_valid  output  1  output qualifier.
REQ-016 SHALL have port o_idx  output  NIDX  frame index of the output sample.
REQ-017 SHALL have port o_last  output  1  high when o_valid and o_idx == NPOINT-1.

Function
REQ-018 SHALL compute o_re = i_re*i_tw_re - i_im*i_tw_im and o_im = i_re*i_tw_im + i_im*i_tw_re, signed, exact, no rounding, no truncation, no saturation.
REQ-019 SHALL sign-extend each partial product to NBITS_OUT before add/sub; no overflow possible at any input pair, including all-most-negative operands.
REQ-020 SHALL use three register stages: S1 input registers, S2 four product registers, S3 add/sub registers driving o_re/o_im; latency exactly 3 enabled cycles.
REQ-021 SHALL carry valid and index alongside data through all three stages so o_valid, o_idx, o_last are aligned with o_re/o_im.
REQ-022 SHALL, when i_en is low, hold every register (data, valid, index, counter); outputs stay constant.
REQ-023 SHALL advance the pipeline on every enabled cycle regardless of i_valid; bubbles propagate as o_valid=0.
REQ-024 SHALL keep an input sample counter cnt (NIDX bits); an accepted sample is i_en && i_valid.
REQ-025 SHALL tag an accepted sample with index 0 and set cnt to 1 when i_sync is high; otherwise tag with cnt and increment cnt modulo NPOINT.
REQ-026 SHALL ignore i_sync when i_valid is low; sync on the wrap sample (cnt == NPOINT-1) wins, tag 0.
REQ-027 SHALL hold o_re/o_im at their last computed value when o_valid is low; downstream qualifies on o_valid only.

Reset
REQ-028 SHALL, on rst high, asynchronously clear all pipeline registers, cnt, o_re, o_im, o_idx to 0 and o_valid, o_last to 0.
REQ-029 SHALL discard in-flight samples on reset mid-frame; the first accepted sample after reset gets index 0 even without i_sync.
REQ-030 SHALL begin accepting samples on the first rising clk edge after rst deasserts.

Verification
REQ-031 Bench SHALL apply i_re=64, i_im=0, tw=(127,0), i_sync=1 -> 3 cycles later o_re=8128, o_im=0, o_idx=0, o_valid=1.
REQ-032 Bench SHALL apply i_re=i_im=i_tw_re=i_tw_im=-128 -> o_re=0, o_im=32768 (17-bit), no overflow.
REQ-033 Bench SHALL stream 130 valid samples with i_sync on the first -> o_last on 128th output only, o_idx wraps 127->0->1.
REQ-034 Bench SHALL drop i_en for 5 cycles mid-stream -> all outputs frozen, latency resumes counting with no lost or duplicated sample.
REQ-035 Bench SHALL assert rst for 1 cycle while 3 samples are in flight -> o_valid=0 immediately, those samples never appear, next sample gets o_idx=0.
REQ-036 Bench SHALL drive 10k random operands with random i_valid gaps -> bit-exact match to a reference model of REQ-018.
